// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the stream_mux_rr funnel.
package stream_mux_rr_pkg;

    // Selection modes driven on the mode input.
    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Channel-index width: clog2(n), never less than one bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr,
// wrapping modulo N, wins.
module rr_arbiter
    import stream_mux_rr_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = clog2_min1(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_any
);

    logic [N-1:0] req_rot;

    // Map a rotated position back to an absolute channel index (ptr < N, so one subtract suffices).
    function automatic logic [SELW-1:0] wrap_idx(input int s);
        int t;
        t = s;
        if (t >= N) begin
            t = t - N;
        end
        return t[SELW-1:0];
    endfunction

    // Rotate requests so ptr sits at bit 0, then take the lowest set bit.
    always_comb begin
        req_rot = N'({req, req} >> ptr);
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                gnt_any = 1'b1;
                gnt_idx = wrap_idx(int'(ptr) + i);
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream funnel with explicit-select or round-robin
// selection, per-packet channel lock and a single registered output stage.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 8,
    parameter int SELW = clog2_min1(N)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic [SELW-1:0] out_chan,
    output logic            out_valid,
    input  logic            out_ready
);

    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_data_q,  out_data_d;
    logic            out_last_q,  out_last_d;
    logic [SELW-1:0] out_chan_q,  out_chan_d;
    logic [SELW-1:0] ptr_q,       ptr_d;
    logic            locked_q,    locked_d;
    logic [SELW-1:0] lock_chan_q, lock_chan_d;

    logic [SELW-1:0] arb_gnt;
    logic            arb_any;
    logic [SELW-1:0] gnt;
    logic            gnt_any;
    logic            can_load;
    logic            sel_valid;
    logic [W-1:0]    sel_data;
    logic            sel_last;
    logic            accept;

    // Round-robin successor of a channel, wrapping N-1 back to 0.
    function automatic logic [SELW-1:0] next_ptr(input logic [SELW-1:0] g);
        if (int'(g) >= N - 1) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    rr_arbiter #(
        .N    (N),
        .SELW (SELW)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_idx (arb_gnt),
        .gnt_any (arb_any)
    );

    // Grant decision: a held lock overrides both mode and sel.
    always_comb begin
        can_load = !out_valid_q || out_ready;
        gnt      = '0;
        gnt_any  = 1'b0;
        if (locked_q) begin
            gnt     = lock_chan_q;
            gnt_any = 1'b1;
        end else if (mode == MODE_SEL) begin
            gnt     = sel;
            gnt_any = (int'(sel) < N);
        end else begin
            gnt     = arb_gnt;
            gnt_any = arb_any;
        end
    end

    // Steer the granted channel's beat and raise only its ready (held low during reset).
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_last  = 1'b0;
        in_ready  = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_any && (gnt == SELW'(i))) begin
                sel_valid   = in_valid[i];
                sel_data    = in_data[i*W +: W];
                sel_last    = in_last[i];
                in_ready[i] = can_load && !reset;
            end
        end
        accept = sel_valid && can_load && !reset;
    end

    // Next-state for the output register, packet lock and rr pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        locked_d    = locked_q;
        lock_chan_d = lock_chan_q;
        if (can_load) begin
            out_valid_d = accept;
            if (accept) begin
                out_data_d = sel_data;
                out_last_d = sel_last;
                out_chan_d = (N == 1) ? '0 : gnt;
            end
        end
        if (accept) begin
            locked_d    = !sel_last;
            lock_chan_d = gnt;
            if (sel_last && (mode == MODE_RR)) begin
                ptr_d = next_ptr(gnt);
            end
        end
    end

    // State registers with synchronous reset; reset also discards a held beat and lock.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
            locked_q    <= 1'b0;
            lock_chan_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
            locked_q    <= locked_d;
            lock_chan_q <= lock_chan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr (N=4, W=8, 3-bit select so out-of-range sel is reachable).
module tb_stream_mux_rr;

    logic        clock;
    logic        reset;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  out_data;
    logic        out_last;
    logic [2:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state (what the output register, lock and pointer must hold).
    logic       m_ov = 1'b0, n_ov = 1'b0;
    logic [7:0] m_od = 8'h0, n_od = 8'h0;
    logic       m_ol = 1'b0, n_ol = 1'b0;
    int         m_oc = 0,    n_oc = 0;
    int         m_ptr = 0,   n_ptr = 0;
    logic       m_lk = 1'b0, n_lk = 1'b0;
    int         m_lch = 0,   n_lch = 0;
    int         g;
    logic       can;
    logic       acc;
    logic [3:0] exp_rdy;

    stream_mux_rr #(
        .N    (4),
        .W    (8),
        .SELW (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 4'b0;
        repeat (n) step();
    endtask

    task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Every cycle: compare DUT against the model, then work out the model's next state.
    always @(negedge clock) begin
        chk("m_out_valid", {31'b0, out_valid}, {31'b0, m_ov});
        chk("m_out_data",  {24'b0, out_data},  {24'b0, m_od});
        chk("m_out_last",  {31'b0, out_last},  {31'b0, m_ol});
        chk("m_out_chan",  {29'b0, out_chan},  m_oc);
        can = !m_ov || out_ready;
        g = -1;
        if (m_lk) begin
            g = m_lch;
        end else if (mode == 1'b0) begin
            if (sel < 3'd4) g = int'(sel);
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (g < 0 && in_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
        end
        exp_rdy = 4'b0;
        if (!reset && g >= 0 && can) exp_rdy[g] = 1'b1;
        chk("m_in_ready", {28'b0, in_ready}, {28'b0, exp_rdy});
        acc = 1'b0;
        if (exp_rdy != 4'b0) acc = in_valid[g];
        n_ov = m_ov; n_od = m_od; n_ol = m_ol; n_oc = m_oc;
        n_ptr = m_ptr; n_lk = m_lk; n_lch = m_lch;
        if (reset) begin
            n_ov = 1'b0; n_od = 8'h0; n_ol = 1'b0; n_oc = 0;
            n_ptr = 0; n_lk = 1'b0; n_lch = 0;
        end else begin
            if (can) begin
                n_ov = acc;
                if (acc) begin
                    n_od = in_data[g*8 +: 8];
                    n_ol = in_last[g];
                    n_oc = g;
                end
            end
            if (acc) begin
                n_lk  = !in_last[g];
                n_lch = g;
                if (in_last[g] && mode) n_ptr = (g + 1) % 4;
            end
        end
    end

    always @(posedge clock) begin
        m_ov <= n_ov; m_od <= n_od; m_ol <= n_ol; m_oc <= n_oc;
        m_ptr <= n_ptr; m_lk <= n_lk; m_lch <= n_lch;
    end

    initial begin
        reset = 1'b1; mode = 1'b1; sel = 3'd0;
        in_valid = 4'hF; in_last = 4'hF; in_data = 32'h13121110; out_ready = 1'b1;

        // Reset held two cycles with every input active.
        repeat (2) begin
            step();
            #2;
            chk("rst_valid", {31'b0, out_valid}, 32'd0);
            chk("rst_data",  {24'b0, out_data},  32'd0);
            chk("rst_ready", {28'b0, in_ready},  32'd0);
        end
        reset = 1'b0;
        #1;
        chk("first_ready", {28'b0, in_ready}, 32'h1);
        step();
        #2;
        chk("first_valid", {31'b0, out_valid}, 32'd1);
        chk("first_chan",  {29'b0, out_chan},  32'd0);
        idle(3);

        // Explicit select of channel 2, then an out-of-range select.
        mode = 1'b0; sel = 3'd2; in_valid = 4'b0100; in_last = 4'hF;
        set_data(8'h00, 8'h00, 8'hA5, 8'h00);
        #2;
        chk("sel2_ready", {28'b0, in_ready}, 32'h4);
        step();
        in_valid = 4'b0;
        #2;
        chk("sel2_data", {24'b0, out_data}, 32'hA5);
        chk("sel2_chan", {29'b0, out_chan}, 32'd2);
        chk("sel2_last", {31'b0, out_last}, 32'd1);
        sel = 3'd5; in_valid = 4'hF;
        #1;
        chk("sel5_ready", {28'b0, in_ready}, 32'h0);
        step();
        #2;
        chk("sel5_valid", {31'b0, out_valid}, 32'd0);
        in_valid = 4'b0;
        do_reset();

        // Round robin over four single-beat producers.
        mode = 1'b1; in_valid = 4'hF; in_last = 4'hF;
        set_data(8'h10, 8'h11, 8'h12, 8'h13);
        step();
        for (int k = 0; k < 5; k++) begin
            #2;
            chk("rr_chan", {29'b0, out_chan}, k % 4);
            chk("rr_data", {24'b0, out_data}, 32'h10 + (k % 4));
            if (k < 4) step();
        end
        idle(2);

        // Three-beat packet on ch1 with mode/sel changing underneath it.
        mode = 1'b0; sel = 3'd1; in_valid = 4'b0111; in_last = 4'b0101;
        set_data(8'h0A, 8'h21, 8'h0C, 8'h00);
        #2;
        chk("lock_rdy0", {28'b0, in_ready}, 32'h2);
        step();
        mode = 1'b1; sel = 3'd3;
        set_data(8'h0A, 8'h22, 8'h0C, 8'h00);
        #2;
        chk("lock_b1", {24'b0, out_data}, 32'h21);
        chk("lock_c1", {29'b0, out_chan}, 32'd1);
        chk("lock_rdy1", {28'b0, in_ready}, 32'h2);
        step();
        sel = 3'd0; in_last = 4'b0111;
        set_data(8'h0A, 8'h23, 8'h0C, 8'h00);
        #2;
        chk("lock_b2", {24'b0, out_data}, 32'h22);
        chk("lock_rdy2", {28'b0, in_ready}, 32'h2);
        step();
        in_valid = 4'b0101;
        #2;
        chk("lock_b3", {24'b0, out_data}, 32'h23);
        chk("lock_l3", {31'b0, out_last}, 32'd1);
        chk("after_rdy", {28'b0, in_ready}, 32'h4);
        step();
        in_valid = 4'b0;
        #2;
        chk("after_chan", {29'b0, out_chan}, 32'd2);
        chk("after_data", {24'b0, out_data}, 32'h0C);
        idle(2);

        // Backpressure: hold the output for three cycles, then release with no bubble.
        mode = 1'b1; in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
        set_data(8'h30, 8'h31, 8'h32, 8'h33);
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("bp_data",  {24'b0, out_data},  32'h33);
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_ready", {28'b0, in_ready},  32'h0);
            if (k < 2) step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_rdy", {28'b0, in_ready}, 32'h1);
        step();
        #2;
        chk("bp_next_data",  {24'b0, out_data},  32'h30);
        chk("bp_next_valid", {31'b0, out_valid}, 32'd1);
        idle(2);

        // Reset in the middle of a locked ch3 packet.
        mode = 1'b1; in_valid = 4'b1000; in_last = 4'b0000;
        set_data(8'h40, 8'h41, 8'h42, 8'h43);
        step();
        step();
        reset = 1'b1; in_valid = 4'b1001;
        #2;
        chk("mid_rst_ready", {28'b0, in_ready}, 32'h0);
        step();
        reset = 1'b0;
        #2;
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_ready2", {28'b0, in_ready}, 32'h1);
        step();
        #2;
        chk("mid_rst_chan", {29'b0, out_chan}, 32'd0);
        chk("mid_rst_data", {24'b0, out_data}, 32'h40);
        idle(2);

        // Randomised traffic checked by the model every cycle.
        for (int c = 0; c < 2000; c++) begin
            step();
            reset     = ($urandom_range(0, 149) == 0);
            in_valid  = 4'($urandom);
            in_last   = 4'($urandom) | 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) sel = 3'($urandom);
        end
        reset = 1'b0; out_ready = 1'b1;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
